// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant bus between the MEM stage and data memory.
// master = MEM-stage unit, slave = memory side.
interface mem_access_unit_if;
  logic        DMReq_OUT;
  logic        DMWe_OUT;
  logic [31:0] DMAddr_OUT;
  logic [3:0]  DMByteEn_OUT;
  logic [31:0] DMData_OUT;
  logic        DMGnt_IN;
  logic [31:0] DMData_IN;
  logic        DMDataValid_IN;

  modport master (
    output DMReq_OUT, DMWe_OUT, DMAddr_OUT, DMByteEn_OUT, DMData_OUT,
    input  DMGnt_IN, DMData_IN, DMDataValid_IN
  );

  modport slave (
    input  DMReq_OUT, DMWe_OUT, DMAddr_OUT, DMByteEn_OUT, DMData_OUT,
    output DMGnt_IN, DMData_IN, DMDataValid_IN
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: MIPS loads/stores incl. LWL/LWR/SWL/SWR,
// request/grant memory handshake, pipeline stall and bus timeout.
module mem_access_unit #(
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Valid_IN,
  input  logic [5:0]  MemControl_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] MemWriteData_IN,
  output logic        Stall_OUT,
  output logic [31:0] WriteData_OUT,
  output logic        WriteDataValid_OUT,
  output logic        Fault_OUT,
  mem_access_unit_if.master dm
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_q;
  logic [31:0]      result;
  logic             fault_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      data_q;

  logic is_lb, is_lbu, is_lh, is_lhu, is_lwl, is_lwr, is_lw;
  logic is_sb, is_sh, is_sw, is_swl, is_swr;
  logic is_load, is_store, is_mem, misalign;

  assign is_lb  = (MemControl_IN == 6'd33);
  assign is_lbu = (MemControl_IN == 6'd42);
  assign is_lh  = (MemControl_IN == 6'd43);
  assign is_lhu = (MemControl_IN == 6'd44);
  assign is_lwl = (MemControl_IN == 6'd45);
  assign is_lwr = (MemControl_IN == 6'd46);
  assign is_lw  = (MemControl_IN == 6'd40) |
                  (MemControl_IN == 6'd53) |
                  (MemControl_IN == 6'd61);
  assign is_sb  = (MemControl_IN == 6'd47);
  assign is_sh  = (MemControl_IN == 6'd48);
  assign is_sw  = (MemControl_IN == 6'd49) |
                  (MemControl_IN == 6'd54);
  assign is_swl = (MemControl_IN == 6'd50);
  assign is_swr = (MemControl_IN == 6'd51);

  assign is_load  = is_lb | is_lbu | is_lh | is_lhu |
                    is_lwl | is_lwr | is_lw;
  assign is_store = is_sb | is_sh | is_sw | is_swl | is_swr;
  assign is_mem   = is_load | is_store;

  assign misalign =
    ((is_lh | is_lhu | is_sh) & ALUResult_IN[0]) |
    ((is_lw | is_sw) & (|ALUResult_IN[1:0]));

  // e is the offset in big-endian numbering; lane/hsh locate the
  // addressed byte and halfword inside the 32-bit word.
  logic [1:0] ofs, e, lane, hsh;
  assign ofs  = ALUResult_IN[1:0];
  assign e    = BIG_ENDIAN ? ofs : ~ofs;
  assign lane = ~e;
  assign hsh  = {~e[1], 1'b0};

  logic [31:0] rt, word, ld_data, st_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [3:0]  st_be;

  assign rt   = MemWriteData_IN;
  assign word = dm.DMData_IN;
  assign ld_b = 8'(word >> {lane, 3'b000});
  assign ld_h = 16'(word >> {hsh, 3'b000});

  // Align and extend the returned word; LWL/LWR merge with rt.
  always_comb begin
    ld_data = word;
    unique case (1'b1)
      is_lb:   ld_data = {{24{ld_b[7]}}, ld_b};
      is_lbu:  ld_data = {24'd0, ld_b};
      is_lh:   ld_data = {{16{ld_h[15]}}, ld_h};
      is_lhu:  ld_data = {16'd0, ld_h};
      is_lwl:  ld_data = (word << {e, 3'b000}) |
                         (rt & ~(32'hFFFF_FFFF << {e, 3'b000}));
      is_lwr:  ld_data = (word >> {~e, 3'b000}) |
                         (rt & ~(32'hFFFF_FFFF >> {~e, 3'b000}));
      default: ld_data = word;
    endcase
  end

  // Position store data on its lanes and build the byte enables.
  always_comb begin
    st_data = rt;
    st_be   = 4'b1111;
    unique case (1'b1)
      is_sb: begin
        st_data = {4{rt[7:0]}};
        st_be   = 4'b0001 << lane;
      end
      is_sh: begin
        st_data = {2{rt[15:0]}};
        st_be   = 4'b0011 << hsh;
      end
      is_swl: begin
        st_data = rt >> {e, 3'b000};
        st_be   = 4'b1111 >> e;
      end
      is_swr: begin
        st_data = rt << {~e, 3'b000};
        st_be   = 4'b1111 << ~e;
      end
      default: ;
    endcase
  end

  // Access FSM with registered bus fields, result and fault pulse.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      load_q  <= 1'b0;
      result  <= '0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Valid_IN && is_mem) begin
            we_q   <= is_store;
            addr_q <= {ALUResult_IN[31:2], 2'b00};
            be_q   <= st_be;
            data_q <= st_data;
            load_q <= is_load;
            cnt    <= '0;
            if (misalign) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (dm.DMGnt_IN && (!load_q || dm.DMDataValid_IN)) begin
            if (load_q) result <= ld_data;
            state <= S_DONE;
          end else if (cnt == TO_LAST) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else if (dm.DMGnt_IN) begin
            state <= S_WAIT;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (dm.DMDataValid_IN) begin
            result <= ld_data;
            state  <= S_DONE;
          end else if (cnt == TO_LAST) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Stall_OUT = ~RESET & (
    ((state == S_IDLE) & Valid_IN & is_mem) |
    (state == S_REQ) | (state == S_WAIT));

  assign WriteDataValid_OUT = (state == S_DONE) |
    ((state == S_IDLE) & Valid_IN & ~is_mem);

  assign WriteData_OUT = ((state == S_DONE) && load_q) ?
                         result : ALUResult_IN;

  assign Fault_OUT       = fault_q;
  assign dm.DMReq_OUT    = req_q;
  assign dm.DMWe_OUT     = we_q;
  assign dm.DMAddr_OUT   = addr_q;
  assign dm.DMByteEn_OUT = be_q;
  assign dm.DMData_OUT   = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus
// hand sequences for reset, late data and invalid slots.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [5:0]  ctrl;
  logic [31:0] alu;
  logic [31:0] rt;
  logic        stall;
  logic [31:0] wd;
  logic        wdv;
  logic        fault;

  mem_access_unit_if dm ();

  mem_access_unit #(
    .BIG_ENDIAN(1'b1),
    .TIMEOUT_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .Valid_IN(valid),
    .MemControl_IN(ctrl),
    .ALUResult_IN(alu),
    .MemWriteData_IN(rt),
    .Stall_OUT(stall),
    .WriteData_OUT(wd),
    .WriteDataValid_OUT(wdv),
    .Fault_OUT(fault),
    .dm(dm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [5:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          gw;
    int          dw;
    int          lat;
    int          reqs;
    logic        flt;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] dat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int          req_n = 0;
    int          g_at = 0;
    int          lat = 0;
    int          stalls = 0;
    bit          granted = 0;
    bit          done = 0;
    bit          seen = 0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_dat = '0;
    logic [3:0]  c_be = '0;
    logic        c_we = 1'b0;
    logic [31:0] got_wd = '0;
    logic        got_flt = 1'b0;
    logic        got_stall = 1'b0;
    valid = 1'b1;
    ctrl  = v.ctrl;
    alu   = v.addr;
    rt    = v.rt;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (wdv || fault) begin
        done      = 1;
        lat       = c;
        got_wd    = wd;
        got_flt   = fault;
        got_stall = stall;
      end else begin
        if (stall) stalls++;
        if (dm.DMReq_OUT) begin
          if (!seen) begin
            c_addr = dm.DMAddr_OUT;
            c_dat  = dm.DMData_OUT;
            c_be   = dm.DMByteEn_OUT;
            c_we   = dm.DMWe_OUT;
          end
          seen = 1;
          if (req_n == v.gw) begin
            dm.DMGnt_IN = 1'b1;
            granted = 1;
            g_at = c;
            if (v.dw == 0) begin
              dm.DMDataValid_IN = 1'b1;
              dm.DMData_IN = v.rdata;
            end
          end
          req_n++;
        end else if (granted && (c - g_at) == v.dw) begin
          dm.DMDataValid_IN = 1'b1;
          dm.DMData_IN = v.rdata;
        end
        @(posedge clk);
        #1;
        dm.DMGnt_IN = 1'b0;
        dm.DMDataValid_IN = 1'b0;
        dm.DMData_IN = 32'h5A5A_A5A5;
      end
    end
    chk({v.nm, " done"}, 32'(done), 32'd1);
    chk({v.nm, " latency"}, lat, v.lat);
    chk({v.nm, " stall cycles"}, stalls, v.lat - 1);
    chk({v.nm, " stall at end"}, 32'(got_stall), 32'd0);
    chk({v.nm, " req cycles"}, req_n, v.reqs);
    chk({v.nm, " fault"}, 32'(got_flt), 32'(v.flt));
    if (!v.flt) chk({v.nm, " wdata"}, got_wd, v.wd);
    if (v.reqs > 0) begin
      chk({v.nm, " addr"}, c_addr, {v.addr[31:2], 2'b00});
      chk({v.nm, " we"}, 32'(c_we), 32'(v.we));
      chk({v.nm, " byteen"}, 32'(c_be), 32'(v.be));
      if (v.we) chk({v.nm, " st data"}, c_dat, v.dat);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    ctrl  = 6'd0;
  endtask

  vec_t vt[$];

  initial begin
    //     nm        ctrl  addr          rt            rdata        gw dw lat req flt wd            we    be       dat
    vt.push_back('{"lb",   6'd33, 32'h1001, 32'h0, 32'h12F45678, 0, 0, 3, 1, 0, 32'hFFFFFFF4, 0, 4'hF, 32'h0});
    vt.push_back('{"lbu",  6'd42, 32'h1001, 32'h0, 32'h12F45678, 0, 0, 3, 1, 0, 32'h000000F4, 0, 4'hF, 32'h0});
    vt.push_back('{"lb3",  6'd33, 32'h1003, 32'h0, 32'h12F45678, 0, 0, 3, 1, 0, 32'h00000078, 0, 4'hF, 32'h0});
    vt.push_back('{"lwl",  6'd45, 32'h2002, 32'hAABBCCDD, 32'h11223344, 0, 2, 5, 1, 0, 32'h3344CCDD, 0, 4'hF, 32'h0});
    vt.push_back('{"lwr",  6'd46, 32'h2002, 32'hAABBCCDD, 32'h11223344, 0, 2, 5, 1, 0, 32'hAA112233, 0, 4'hF, 32'h0});
    vt.push_back('{"lwr0", 6'd46, 32'h2000, 32'hAABBCCDD, 32'h11223344, 0, 0, 3, 1, 0, 32'hAABBCC11, 0, 4'hF, 32'h0});
    vt.push_back('{"swr",  6'd51, 32'h3001, 32'h11223344, 32'h0, 0, 0, 3, 1, 0, 32'h00003001, 1, 4'hC, 32'h33440000});
    vt.push_back('{"sh",   6'd48, 32'h3002, 32'h11223344, 32'h0, 1, 0, 4, 2, 0, 32'h00003002, 1, 4'h3, 32'h33443344});
    vt.push_back('{"lwmis",6'd40, 32'h4002, 32'h0, 32'h0, 0, 0, 2, 0, 1, 32'h0, 0, 4'h0, 32'h0});
    vt.push_back('{"lh",   6'd43, 32'h5000, 32'h0, 32'h80017FFE, 1, 0, 4, 2, 0, 32'hFFFF8001, 0, 4'hF, 32'h0});
    vt.push_back('{"lhu",  6'd44, 32'h5002, 32'h0, 32'h1234ABCD, 0, 0, 3, 1, 0, 32'h0000ABCD, 0, 4'hF, 32'h0});
    vt.push_back('{"sb",   6'd47, 32'h6003, 32'h000000A5, 32'h0, 0, 0, 3, 1, 0, 32'h00006003, 1, 4'h1, 32'hA5A5A5A5});
    vt.push_back('{"swl",  6'd50, 32'h7001, 32'h11223344, 32'h0, 0, 0, 3, 1, 0, 32'h00007001, 1, 4'h7, 32'h00112233});
    vt.push_back('{"sw",   6'd54, 32'h8000, 32'hDEADBEEF, 32'h0, 0, 0, 3, 1, 0, 32'h00008000, 1, 4'hF, 32'hDEADBEEF});
    vt.push_back('{"lw",   6'd61, 32'h9000, 32'h0, 32'hCAFEF00D, 0, 1, 4, 1, 0, 32'hCAFEF00D, 0, 4'hF, 32'h0});
    vt.push_back('{"alu",  6'd0,  32'h13579BDF, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h13579BDF, 0, 4'h0, 32'h0});
    vt.push_back('{"shmis",6'd48, 32'h3001, 32'h0, 32'h0, 0, 0, 2, 0, 1, 32'h0, 0, 4'h0, 32'h0});
    vt.push_back('{"tmo",  6'd40, 32'hA000, 32'h0, 32'h0, 99, 0, 6, 4, 1, 32'h0, 0, 4'hF, 32'h0});

    rst   = 1'b1;
    valid = 1'b0;
    ctrl  = 6'd0;
    alu   = 32'h0;
    rt    = 32'h0;
    dm.DMGnt_IN       = 1'b0;
    dm.DMDataValid_IN = 1'b0;
    dm.DMData_IN      = 32'h0;

    @(negedge clk);
    chk("rst req", 32'(dm.DMReq_OUT), 32'd0);
    chk("rst we", 32'(dm.DMWe_OUT), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst wdv", 32'(wdv), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst byteen", 32'(dm.DMByteEn_OUT), 32'd0);
    chk("rst addr", dm.DMAddr_OUT, 32'd0);
    chk("rst data", dm.DMData_OUT, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Late data after the timeout fault must be ignored.
    alu = 32'h5555AAAA;
    dm.DMDataValid_IN = 1'b1;
    dm.DMData_IN = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("late wd", wd, 32'h5555AAAA);
      chk("late wdv", 32'(wdv), 32'd0);
      chk("late stall", 32'(stall), 32'd0);
      chk("late fault", 32'(fault), 32'd0);
    end
    @(posedge clk);
    #1;
    dm.DMDataValid_IN = 1'b0;

    // Invalid slot carrying a load code: pass-through, no request.
    valid = 1'b0;
    ctrl  = 6'd40;
    alu   = 32'h00004444;
    #1;
    chk("inv stall", 32'(stall), 32'd0);
    chk("inv wdv", 32'(wdv), 32'd0);
    chk("inv wd", wd, 32'h00004444);
    @(posedge clk);
    #1;
    chk("inv req", 32'(dm.DMReq_OUT), 32'd0);

    // Reset while waiting for load data.
    valid = 1'b1;
    ctrl  = 6'd40;
    alu   = 32'h0000B000;
    @(posedge clk);
    #1;
    chk("rw req", 32'(dm.DMReq_OUT), 32'd1);
    dm.DMGnt_IN = 1'b1;
    @(posedge clk);
    #1;
    dm.DMGnt_IN = 1'b0;
    chk("rw wait stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw stall", 32'(stall), 32'd0);
    chk("rw req off", 32'(dm.DMReq_OUT), 32'd0);
    chk("rw addr", dm.DMAddr_OUT, 32'd0);
    dm.DMDataValid_IN = 1'b1;
    dm.DMData_IN = 32'h77777777;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dm.DMDataValid_IN = 1'b0;
    ctrl = 6'd0;
    alu  = 32'h2468ACE0;
    #1;
    chk("rw alu wdv", 32'(wdv), 32'd1);
    chk("rw alu wd", wd, 32'h2468ACE0);
    chk("rw alu stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    chk("rw alu req", 32'(dm.DMReq_OUT), 32'd0);
    chk("rw alu fault", 32'(fault), 32'd0);
    valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
